// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers pixel position from received VGA syncs, tracks
// timing lock, and captures the colour of one probed pixel on request.
//
// Probe handshake: the requester raises i_probe_req with i_probe_x/i_probe_y
// stable and keeps it high. When that pixel is sampled while locked,
// o_probe_ack pulses for one clock together with the new o_probe_rgb. A
// further ack needs i_probe_req to be seen low for at least one clock first.
// Dropping i_probe_req before the match cancels the request. Losing lock
// leaves the request pending.
//
// o_dbg_state mirrors the lock FSM: 0 = SEARCH, 1 = ACQUIRE, 2 = LOCKED.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_START  = 144,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_START  = 35,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic [3:0]  i_r,
  input  logic [3:0]  i_g,
  input  logic [3:0]  i_b,
  input  logic        i_probe_req,
  input  logic [9:0]  i_probe_x,
  input  logic [8:0]  i_probe_y,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_de,
  output logic        o_locked,
  output logic        o_err_h,
  output logic        o_err_v,
  output logic [15:0] o_frame_cnt,
  output logic        o_probe_ack,
  output logic [11:0] o_probe_rgb,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam logic [9:0] CNT_MAX     = 10'h3FF;
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] H_FIRST     = 10'(H_START);
  localparam logic [9:0] H_END       = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [9:0] V_FIRST     = 10'(V_START);
  localparam logic [9:0] V_END       = 10'(V_START + V_ACTIVE - 1);
  localparam logic [8:0] V_FIRST9    = 9'(V_START);

  state_e      state_q, state_d;
  logic [1:0]  good_q, good_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic        h_seen_q, h_seen_d;
  logic        v_seen_q, v_seen_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        err_h_q, err_h_d;
  logic        err_v_q, err_v_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        de_q, de_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        ack_q, ack_d;
  logic [11:0] rgb_q, rgb_d;
  logic        ack_block_q, ack_block_d;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic        err_h_now, err_v_now;
  logic [9:0]  h_next, v_next;
  logic        locked, pix_de, probe_hit;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;

  // Sync edge detection, position counters and line/frame length checks.
  always_comb begin
    hs_fall   = i_pix_stb && hs_prev_q && !i_hs;
    hs_rise   = i_pix_stb && !hs_prev_q && i_hs;
    // vs is only looked at on the strobe that starts a line.
    vs_fall   = hs_fall && vs_prev_q && !i_vs;
    vs_rise   = hs_fall && !vs_prev_q && i_vs;
    h_next    = hs_fall ? 10'd0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1);
    v_next    = v_cnt_q;
    if (hs_fall) begin
      v_next = vs_fall ? 10'd0 : ((v_cnt_q == CNT_MAX) ? v_cnt_q : v_cnt_q + 10'd1);
    end
    hs_prev_d = i_pix_stb ? i_hs : hs_prev_q;
    vs_prev_d = hs_fall ? i_vs : vs_prev_q;
    h_cnt_d   = i_pix_stb ? h_next : h_cnt_q;
    v_cnt_d   = v_next;
    err_h_now = h_seen_q && ((hs_fall && (h_cnt_q != H_LAST)) ||
                             (hs_rise && (h_cnt_q != H_SYNC_LAST)));
    err_v_now = v_seen_q && ((vs_fall && (v_cnt_q != V_LAST)) ||
                             (vs_rise && (v_cnt_q != V_SYNC_LAST)));
    err_h_d   = err_h_now;
    err_v_d   = err_v_now;
  end

  // Lock FSM: next state, good-frame count, locked frame count, check enables.
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_cnt_d = frame_cnt_q;
    h_seen_d    = h_seen_q;
    v_seen_d    = v_seen_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d = ST_ACQUIRE;
          good_d  = 2'd0;
        end
      end
      ST_ACQUIRE: begin
        if (err_h_q || err_v_q) begin
          state_d = ST_SEARCH;
        end else if (vs_fall) begin
          // A frame ending in an error at its own closing edge is not good.
          if (err_h_now || err_v_now) begin
            state_d = ST_SEARCH;
          end else begin
            good_d = good_q + 2'd1;
            if (good_q == 2'd1) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (vs_fall) frame_cnt_d = frame_cnt_q + 16'd1;
        if (err_h_q || err_v_q) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
    // Re-entering SEARCH re-arms the "first edge" suppression of the checks.
    if ((state_d == ST_SEARCH) && (state_q != ST_SEARCH)) begin
      h_seen_d = 1'b0;
      v_seen_d = 1'b0;
    end else begin
      if (hs_fall) h_seen_d = 1'b1;
      if (vs_fall) v_seen_d = 1'b1;
    end
  end

  // Active-region position of the sampled pixel and probe capture.
  always_comb begin
    locked      = (state_q == ST_LOCKED);
    pix_de      = locked && (h_next >= H_FIRST) && (h_next <= H_END) &&
                  (v_next >= V_FIRST) && (v_next <= V_END);
    pix_x       = pix_de ? (h_next - H_FIRST) : 10'd0;
    pix_y       = pix_de ? (v_next[8:0] - V_FIRST9) : 9'd0;
    de_d        = i_pix_stb ? pix_de : de_q;
    x_d         = i_pix_stb ? pix_x : x_q;
    y_d         = i_pix_stb ? pix_y : y_q;
    probe_hit   = i_pix_stb && i_probe_req && !ack_block_q && pix_de &&
                  (pix_x == i_probe_x) && (pix_y == i_probe_y);
    ack_d       = probe_hit;
    rgb_d       = probe_hit ? {i_r, i_g, i_b} : rgb_q;
    ack_block_d = probe_hit ? 1'b1 : (i_probe_req ? ack_block_q : 1'b0);
  end

  // State register; everything clears asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_SEARCH;
      good_q      <= 2'd0;
      hs_prev_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      h_seen_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 10'd0;
      err_h_q     <= 1'b0;
      err_v_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      de_q        <= 1'b0;
      x_q         <= 10'd0;
      y_q         <= 9'd0;
      ack_q       <= 1'b0;
      rgb_q       <= 12'd0;
      ack_block_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      h_seen_q    <= h_seen_d;
      v_seen_q    <= v_seen_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      err_h_q     <= err_h_d;
      err_v_q     <= err_v_d;
      frame_cnt_q <= frame_cnt_d;
      de_q        <= de_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ack_q       <= ack_d;
      rgb_q       <= rgb_d;
      ack_block_q <= ack_block_d;
    end
  end

  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_de        = de_q;
  assign o_locked    = (state_q == ST_LOCKED);
  assign o_err_h     = err_h_q;
  assign o_err_v     = err_v_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_probe_ack = ack_q;
  assign o_probe_rgb = rgb_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor with a shrunken video timing so that many frames
// fit in a short run. A strobe-level reference model predicts every output.
module tb_vga_sync_monitor;
  localparam int HT  = 40;
  localparam int HSY = 6;
  localparam int HST = 10;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VSY = 2;
  localparam int VST = 4;
  localparam int VA  = 12;

  logic        clk = 1'b0;
  logic        i_rst_n, i_pix_stb, i_hs, i_vs, i_probe_req;
  logic [3:0]  i_r, i_g, i_b;
  logic [9:0]  i_probe_x;
  logic [8:0]  i_probe_y;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic        o_de, o_locked, o_err_h, o_err_v, o_probe_ack;
  logic [15:0] o_frame_cnt;
  logic [11:0] o_probe_rgb;
  logic [1:0]  o_dbg_state;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HSY), .H_START(HST), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VSY), .V_START(VST), .V_ACTIVE(VA)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb),
    .i_hs(i_hs), .i_vs(i_vs), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_probe_req(i_probe_req), .i_probe_x(i_probe_x), .i_probe_y(i_probe_y),
    .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_locked(o_locked),
    .o_err_h(o_err_h), .o_err_v(o_err_v), .o_frame_cnt(o_frame_cnt),
    .o_probe_ack(o_probe_ack), .o_probe_rgb(o_probe_rgb), .o_dbg_state(o_dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: lock state 0/1/2 = search/acquire/locked.
  int m_state, m_good, m_h_seen, m_v_seen, m_last_h, m_v, m_prev_vs;
  int m_block, m_rgb, m_fcnt, m_pend_err;
  int e_x, e_y, e_de;
  int tgt_x, tgt_y;
  logic [11:0] tgt_rgb;
  int n_ack, n_eh, n_ev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_h_seen = 0; m_v_seen = 0; m_last_h = 0;
    m_v = 0; m_prev_vs = 1; m_block = 0; m_rgb = 0; m_fcnt = 0;
    m_pend_err = 0; e_x = 0; e_y = 0; e_de = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_x"}, o_x, 0);
    chk({tag, "_y"}, o_y, 0);
    chk({tag, "_de"}, o_de, 0);
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_err_h"}, o_err_h, 0);
    chk({tag, "_err_v"}, o_err_v, 0);
    chk({tag, "_fcnt"}, o_frame_cnt, 0);
    chk({tag, "_ack"}, o_probe_ack, 0);
    chk({tag, "_rgb"}, o_probe_rgb, 0);
    chk({tag, "_state"}, o_dbg_state, 0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    if (!i_probe_req) m_block = 0;
  endtask

  // One line: hs low for HSY strobes, strobe every second clock.
  task automatic send_line(input int len, input int line, input logic vsv,
                           input int rst_k, output bit aborted);
    aborted = 0;
    for (int k = 0; k < len; k++) begin
      logic [11:0] rgb;
      bit fall, rise, vsf, vsr, eh, ev, hit, enter;
      int h, lk;
      rgb = 12'($urandom_range(0, 4095));
      if (line == VST + tgt_y && k == HST + tgt_x) rgb = tgt_rgb;
      @(negedge clk);
      if (k == rst_k) begin
        i_pix_stb = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 check_zero("rst_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        aborted = 1;
        return;
      end
      i_pix_stb = 1'b1;
      i_hs = (k < HSY) ? 1'b0 : 1'b1;
      i_vs = vsv;
      {i_r, i_g, i_b} = rgb;
      // model of this strobe
      if (!i_probe_req) m_block = 0;
      lk   = (m_state == 2);
      fall = (k == 0);
      rise = (k == HSY);
      vsf  = fall && (m_prev_vs == 1) && (vsv == 1'b0);
      vsr  = fall && (m_prev_vs == 0) && (vsv == 1'b1);
      eh   = (m_h_seen != 0) && ((fall && m_last_h != HT - 1) || (rise && m_last_h != HSY - 1));
      ev   = (m_v_seen != 0) && ((vsf && m_v != VT - 1) || (vsr && m_v != VSY - 1));
      if (fall) begin
        m_v = vsf ? 0 : ((m_v + 1 > 1023) ? 1023 : m_v + 1);
        m_prev_vs = vsv;
      end
      h = fall ? 0 : ((m_last_h + 1 > 1023) ? 1023 : m_last_h + 1);
      m_last_h = h;
      e_de = (lk != 0) && h >= HST && h < HST + HA && m_v >= VST && m_v < VST + VA;
      e_x  = e_de ? h - HST : 0;
      e_y  = e_de ? m_v - VST : 0;
      hit  = i_probe_req && (m_block == 0) && (e_de != 0) &&
             e_x == int'(i_probe_x) && e_y == int'(i_probe_y);
      if (hit) begin m_rgb = rgb; m_block = 1; end
      enter = 0;
      if (m_state == 0) begin
        if (vsf) begin m_state = 1; m_good = 0; end
      end else if (m_state == 1) begin
        if (vsf) begin
          if (eh || ev) begin m_state = 0; enter = 1; end
          else begin m_good++; if (m_good == 2) m_state = 2; end
        end
      end else begin
        if (vsf) m_fcnt = (m_fcnt + 1) % 65536;
      end
      if (enter) begin m_h_seen = 0; m_v_seen = 0; end
      else begin
        if (fall) m_h_seen = 1;
        if (vsf) m_v_seen = 1;
      end
      m_pend_err = eh || ev;
      @(posedge clk); #1;
      chk("de", o_de, e_de);
      chk("x", o_x, e_x);
      chk("y", o_y, e_y);
      chk("locked", o_locked, (m_state == 2));
      chk("err_h", o_err_h, eh);
      chk("err_v", o_err_v, ev);
      chk("frame_cnt", o_frame_cnt, m_fcnt);
      chk("probe_ack", o_probe_ack, hit);
      chk("probe_rgb", o_probe_rgb, m_rgb);
      n_ack += int'(o_probe_ack);
      n_eh  += int'(o_err_h);
      n_ev  += int'(o_err_v);
      @(negedge clk);
      i_pix_stb = 1'b0;
      @(posedge clk); #1;
      if (!i_probe_req) m_block = 0;
      if (m_pend_err != 0 && m_state != 0) begin
        m_state = 0; m_h_seen = 0; m_v_seen = 0;
      end
      m_pend_err = 0;
      chk("idle_err_h", o_err_h, 0);
      chk("idle_err_v", o_err_v, 0);
      chk("idle_ack", o_probe_ack, 0);
      chk("idle_locked", o_locked, (m_state == 2));
      chk("idle_state", o_dbg_state, m_state);
      chk("idle_de_hold", o_de, e_de);
    end
  endtask

  task automatic send_frame(input int vs_low, input int bad_line,
                            input int rst_line, input int drop_line);
    for (int l = 0; l < VT; l++) begin
      bit ab;
      if (l == drop_line) i_probe_req = 1'b0;
      send_line((l == bad_line) ? HT + 1 : HT, l, (l < vs_low) ? 1'b0 : 1'b1,
                (l == rst_line) ? 15 : -1, ab);
      if (ab) return;
    end
  endtask

  task automatic clear_counts();
    n_ack = 0; n_eh = 0; n_ev = 0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
    i_r = 4'd0; i_g = 4'd0; i_b = 4'd0;
    i_probe_req = 1'b0; i_probe_x = 10'd0; i_probe_y = 9'd0;
    tgt_x = -1000; tgt_y = -1000; tgt_rgb = 12'd0;
    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1 check_zero("por");
    @(negedge clk) i_rst_n = 1'b1;

    // Ideal stream: lock after the third vs falling edge.
    repeat (3) send_frame(VSY, -1, -1, -1);
    chk("locked_after_3_vsf", o_locked, 1);
    chk("fcnt_before_4th", o_frame_cnt, 0);
    chk("no_errors_while_locking", n_eh + n_ev, 0);

    // Probe (5,7) with that pixel driven to ABC.
    tgt_x = 5; tgt_y = 7; tgt_rgb = 12'hABC;
    i_probe_x = 10'd5; i_probe_y = 9'd7; i_probe_req = 1'b1;
    clear_counts();
    send_frame(VSY, -1, -1, -1);
    chk("fcnt_after_4th", o_frame_cnt, 1);
    chk("probe_ack_count", n_ack, 1);
    chk("probe_rgb_abc", o_probe_rgb, 12'hABC);

    // Request still high: no second ack.
    clear_counts();
    send_frame(VSY, -1, -1, -1);
    chk("probe_no_reack", n_ack, 0);

    // Re-armed request dropped at row 3 before row 7: cancelled.
    i_probe_req = 1'b0;
    idle_cycle();
    i_probe_req = 1'b1;
    clear_counts();
    send_frame(VSY, -1, -1, VST + 3);
    chk("probe_cancel_no_ack", n_ack, 0);
    chk("probe_rgb_held", o_probe_rgb, 12'hABC);
    tgt_x = -1000; tgt_y = -1000;

    // One long line while locked.
    clear_counts();
    send_frame(VSY, 8, -1, -1);
    chk("long_line_err_h", n_eh, 1);
    chk("long_line_unlock", o_locked, 0);
    clear_counts();
    repeat (3) send_frame(VSY, -1, -1, -1);
    chk("relock_after_long_line", o_locked, 1);
    chk("relock_no_err", n_eh + n_ev, 0);

    // vs held low for three lines.
    clear_counts();
    send_frame(3, -1, -1, -1);
    chk("long_vsync_err_v", n_ev, 1);
    chk("long_vsync_unlock", o_locked, 0);
    chk("long_vsync_search", o_dbg_state, 0);
    repeat (3) send_frame(VSY, -1, -1, -1);
    chk("relock_after_vsync", o_locked, 1);

    // Random probe point.
    tgt_x = $urandom_range(0, HA - 1);
    tgt_y = $urandom_range(0, VA - 1);
    tgt_rgb = 12'($urandom_range(0, 4095));
    i_probe_x = 10'(tgt_x); i_probe_y = 9'(tgt_y);
    i_probe_req = 1'b1;
    clear_counts();
    send_frame(VSY, -1, -1, -1);
    chk("rand_probe_ack", n_ack, 1);
    chk("rand_probe_rgb", o_probe_rgb, tgt_rgb);
    i_probe_req = 1'b0;
    tgt_x = -1000; tgt_y = -1000;

    // Reset mid-frame, then reacquire.
    send_frame(VSY, -1, 10, -1);
    repeat (2) send_frame(VSY, -1, -1, -1);
    chk("no_lock_after_2_vsf", o_locked, 0);
    send_frame(VSY, -1, -1, -1);
    chk("lock_after_reset", o_locked, 1);
    send_frame(VSY, -1, -1, -1);
    chk("fcnt_after_reset", o_frame_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 SHALL have one clock `i_clk` and an asynchronous, active-low reset `i_rst_n`.
REQ-002 SHALL have ports (direction, width, meaning) as follows:
- i_clk  in  1  system clock, 100 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pix_stb  in  1  one-cycle pixel strobe, 25 MHz rate; all sampling happens only on strobe cycles.
- i_hs, i_vs  in  1 each  received syncs, active-low.
- i_r, i_g, i_b  in  4 each  received colour.
- i_probe_req  in  1  probe request, held high until ack.
- i_probe_x  in  10  probe column; stable while req is high.
- i_probe_y  in  9  probe row; stable while req is high.
- o_x  out  10  recovered active column.
- o_y  out  9  recovered active row.
- o_de  out  1  recovered data-enable.
- o_locked  out  1  timing locked.
- o_err_h, o_err_v  out  1 each  one-cycle timing-error pulses.
- o_frame_cnt  out  16  locked frames seen.
- o_probe_ack  out  1  one-cycle probe acknowledge.
- o_probe_rgb  out  12  captured {r,g,b}.

Function
REQ-003 SHALL use fixed 640x480 timing: line = 800 strobes, hs low = 96 strobes, active columns start 144 strobes after the hs falling edge; frame = 525 lines, vs low = 2 lines, active rows start 35 lines after the vs falling edge.
REQ-004 SHALL hold registered state hs_prev, h_cnt[9:0] and v_cnt[9:0], updated only on i_pix_stb cycles.
REQ-005 SHALL detect an hs falling edge as hs_prev=1 and i_hs=0 on a strobe; on that strobe h_cnt <= 0, otherwise h_cnt <= h_cnt+1, saturating at 1023.
REQ-006 SHALL sample i_vs only on hs-falling-edge strobes; on a vs falling edge at that sample v_cnt <= 0, otherwise v_cnt <= v_cnt+1, saturating at 1023.
REQ-007 SHALL check the line on each hs falling edge: previous h_cnt must equal 799. On the hs rising-edge strobe, h_cnt must equal 95. Any mismatch pulses o_err_h for one clock.
REQ-008 SHALL check the frame on each vs falling edge: previous v_cnt must equal 524. On the vs rising sample, v_cnt must equal 1. Any mismatch pulses o_err_v for one clock.
REQ-009 SHALL suppress the h checks until one hs falling edge has been seen since reset or SEARCH entry, and suppress the v checks likewise until one vs falling edge has been seen.
REQ-010 SHALL implement a lock FSM with states SEARCH, ACQUIRE and LOCKED:
- SEARCH: the first vs falling edge moves to ACQUIRE and sets good=0.
- ACQUIRE: each error-free frame ending at a vs falling edge does good++; good=2 moves to LOCKED; any error moves to SEARCH.
- LOCKED: any error moves to SEARCH on the clock after the error pulse.
REQ-011 SHALL drive o_locked=1 only in LOCKED.
REQ-012 SHALL increment o_frame_cnt on each vs falling edge while in LOCKED, wrapping 65535->0. It holds its value when lock is lost.
REQ-013 SHALL register o_de = locked && h_cnt in [144,783] && v_cnt in [35,514], with o_x = h_cnt-144 and o_y = v_cnt-35 when o_de=1, and 0 otherwise.
REQ-014 SHALL make o_x, o_y and o_de valid from the clock after the strobe that sampled the pixel (latency 1 clock).
REQ-015 SHALL match a pending probe on a strobe where o_locked=1 and the sampled pixel's (x,y) equals (i_probe_x, i_probe_y) in the active region. On a match it captures {i_r,i_g,i_b} into o_probe_rgb and pulses o_probe_ack for one clock.
REQ-016 SHALL NOT acknowledge again until i_probe_req has been seen low for at least one clock.
REQ-017 SHALL cancel a pending probe with no ack if i_probe_req drops before the match. If lock is lost, the probe stays pending.
REQ-018 SHALL hold o_probe_rgb until the next capture.
REQ-019 SHALL handle simultaneous hs and vs falling edges by doing both the v update and the h reset in the same strobe.

Reset
REQ-020 SHALL, on i_rst_n=0, immediately and asynchronously clear every register and output: FSM=SEARCH, all counters 0, hs_prev=1, and no probe pending.
REQ-021 SHALL restart lock acquisition from SEARCH when reset is applied mid-frame.

Verification
REQ-022 Ideal 640x480 stimulus for 4 frames -> o_locked rises one clock after the 3rd vs falling edge; o_frame_cnt=1 after the 4th; no error pulses.
REQ-023 Locked stream -> first active pixel gives o_x=0, o_y=0, o_de=1; column 639 of row 479 gives o_de=1; the next strobe gives o_de=0 with o_x=o_y=0.
REQ-024 One line of 801 strobes while LOCKED -> single o_err_h pulse and o_locked=0 the next clock; relock after 2 further good frames.
REQ-025 vs held low for 3 lines -> o_err_v pulse at the vs rising sample; FSM returns to SEARCH.
REQ-026 Probe (100,200), with pixel (100,200) driven 12'hABC -> one o_probe_ack pulse with o_probe_rgb=12'hABC. Req dropped at row 150 -> no ack.
REQ-027 Reset asserted at line 300 -> all outputs 0 within the same clock; o_locked stays 0 until 3 vs edges after release.
